// File: rtl/reg_serializer.sv
// ---------------------------------------------------------------------------
// reg_serializer
//   Parallel-to-serial transmitter. A word presented on din is captured when
//   load is sampled high while idle, then sent on sout as a framed stream:
//   one start bit (0), WIDTH data bits LSB first, one stop bit (1). Each bit
//   is held for CLK_DIV clock cycles. done pulses for one cycle in the first
//   idle cycle after the stop bit, and a load in that cycle is accepted.
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   din    in   [WIDTH-1:0] word to transmit
//   load   in   transmit request, honoured only when ready
//   ready  out  a load will be accepted on the next edge
//   busy   out  frame in progress (inverse of ready)
//   sout   out  serial line, idles high
//   done   out  one-cycle pulse when a frame completes
// ---------------------------------------------------------------------------
module reg_serializer #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             busy,
  output logic             sout,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_q,   bit_d;
  logic [DW-1:0]    div_q,   div_d;
  logic             sout_q,  sout_d;
  logic             ready_q, ready_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             div_end;

  // With CLK_DIV=1 the divider is a constant 0 and div_end is always true.
  assign div_end = (div_q == DIV_LAST);

  // Outputs are registered, so each branch computes the line level that
  // belongs to the state being entered, not the state being left.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    div_d   = div_q;
    sout_d  = sout_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        sout_d  = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (load) begin
          shift_d = din;
          div_d   = '0;
          bit_d   = '0;
          state_d = START;
          sout_d  = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START: begin
        if (div_end) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = DATA;
          sout_d  = shift_q[0];
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      DATA: begin
        if (div_end) begin
          div_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
            sout_d  = 1'b1;
          end else begin
            bit_d  = bit_q + CW'(1);
            // Next data bit is the one about to shift into position 0.
            sout_d = shift_q[1];
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      STOP: begin
        if (div_end) begin
          div_d   = '0;
          state_d = IDLE;
          sout_d  = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        sout_d  = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      sout_q  <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      sout_q  <= sout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sout  = sout_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_reg_serializer.sv
// ---------------------------------------------------------------------------
// tb_reg_serializer
//   Drives two serializers (CLK_DIV=1 and CLK_DIV=2) from one clock and
//   compares sout/ready/busy/done each cycle against the expected frame
//   built directly from the word: start 0, data LSB first, stop 1, each
//   bit repeated CLK_DIV times, then a done cycle.
// ---------------------------------------------------------------------------
module tb_reg_serializer;

  logic        clk;
  logic        rst_n;
  logic [15:0] din1, din2;
  logic        load1, load2;
  logic        ready1, busy1, sout1, done1;
  logic        ready2, busy2, sout2, done2;

  int checks = 0;
  int errors = 0;

  reg_serializer #(.WIDTH(16), .CLK_DIV(1)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din1),
    .load (load1),
    .ready(ready1),
    .busy (busy1),
    .sout (sout1),
    .done (done1)
  );

  reg_serializer #(.WIDTH(16), .CLK_DIV(2)) u_dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din2),
    .load (load2),
    .ready(ready2),
    .busy (busy2),
    .sout (sout2),
    .done (done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {sout, ready, busy, done}
  function automatic logic [3:0] outs(input int sel);
    return (sel == 0) ? {sout1, ready1, busy1, done1}
                      : {sout2, ready2, busy2, done2};
  endfunction

  localparam logic [3:0] IDLE_OUT = 4'b1100;
  localparam logic [3:0] DONE_OUT = 4'b1101;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed sout/ready/busy/done=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set_load(input int sel, input logic v, input logic [15:0] w);
    if (sel == 0) begin
      load1 = v;
      din1  = w;
    end else begin
      load2 = v;
      din2  = w;
    end
  endtask

  // Called at a negedge; returns at the negedge of the first start cycle.
  task automatic start(input int sel, input logic [15:0] w);
    set_load(sel, 1'b1, w);
    @(posedge clk);
    @(negedge clk);
    set_load(sel, 1'b0, 16'($urandom));
  endtask

  task automatic idle_cycles(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d", sel), outs(sel), IDLE_OUT);
    end
  endtask

  // Starts at the negedge of the first start cycle, ends at the negedge of
  // the done cycle. At frame cycle glitch_k a one-cycle load with a new din
  // is pulsed; it must have no effect on the frame.
  task automatic run_frame(input int sel, input logic [15:0] w, input int glitch_k);
    int d;
    int n;
    int idx;
    logic e;
    d = (sel == 0) ? 1 : 2;
    n = 18 * d;
    for (int k = 0; k < n; k++) begin
      idx = k / d;
      if (idx == 0)       e = 1'b0;
      else if (idx <= 16) e = w[idx-1];
      else                e = 1'b1;
      chk($sformatf("frame%0d w=%h k=%0d", sel, w, k), outs(sel), {e, 1'b0, 1'b1, 1'b0});
      if (k == glitch_k)          set_load(sel, 1'b1, 16'hFFFF);
      else if (k == glitch_k + 1) set_load(sel, 1'b0, 16'($urandom));
      @(negedge clk);
    end
    chk($sformatf("done%0d w=%h", sel, w), outs(sel), DONE_OUT);
  endtask

  initial begin
    logic [15:0] w;
    int sel;
    int gap;

    rst_n = 1'b1;
    load1 = 1'b0;
    load2 = 1'b0;
    din1  = '0;
    din2  = '0;
    #1;
    // Reset held for 3 cycles with a pending load on dut1.
    rst_n = 1'b0;
    load1 = 1'b1;
    din1  = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset1", outs(0), IDLE_OUT);
      chk("reset2", outs(1), IDLE_OUT);
    end
    rst_n = 1'b1;
    #1;
    chk("release1", outs(0), IDLE_OUT);
    @(posedge clk);
    @(negedge clk);
    load1 = 1'b0;
    run_frame(0, 16'hFFFF, -10);
    idle_cycles(0, 2);

    // Single frame, CLK_DIV=1.
    start(0, 16'h0001);
    run_frame(0, 16'h0001, -10);
    idle_cycles(0, 1);

    // Load pulsed during data bit 5 (frame cycle 6) must be ignored.
    start(0, 16'h0002);
    run_frame(0, 16'h0002, 6);
    idle_cycles(0, 3);

    // Back-to-back: load held high through the done cycle.
    start(0, 16'hFFFF);
    set_load(0, 1'b1, 16'h0001);
    run_frame(0, 16'hFFFF, -10);
    @(posedge clk);
    @(negedge clk);
    set_load(0, 1'b0, 16'($urandom));
    run_frame(0, 16'h0001, -10);
    idle_cycles(0, 1);

    // CLK_DIV=2.
    idle_cycles(1, 1);
    start(1, 16'hA5A5);
    run_frame(1, 16'hA5A5, -10);
    idle_cycles(1, 1);

    // Asynchronous reset during data bit 7 of 0x00FF.
    start(0, 16'h00FF);
    repeat (8) @(negedge clk);
    chk("pre_rst", outs(0), 4'b1010);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst", outs(0), IDLE_OUT);
    @(negedge clk);
    chk("rst_hold", outs(0), IDLE_OUT);
    rst_n = 1'b1;
    idle_cycles(0, 2);
    w = 16'($urandom);
    start(0, w);
    run_frame(0, w, -10);

    // Randomised words, DUT choice and gaps (gap 0 is back-to-back).
    for (int it = 0; it < 12; it++) begin
      sel = int'($urandom_range(0, 1));
      gap = int'($urandom_range(0, 3));
      w   = 16'($urandom);
      idle_cycles(sel, gap);
      start(sel, w);
      run_frame(sel, w, (it % 3 == 0) ? int'($urandom_range(1, 15)) : -10);
    end
    idle_cycles(0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
